// File: rtl/oled_pixel_streamer.sv
// Frame walker for the pixel request interface: fetches each pixel colour in raster
// order and shifts it MSB-first onto a write-only SPI link (mode 0) to an ST7735 panel.
module oled_pixel_streamer #(
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 80,
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        next_pixel,
  input  logic [15:0] color,
  input  logic        color_done,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_dc
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       X_LAST   = 8'(X_MAX - 1);
  localparam logic [6:0]       Y_LAST   = 7'(Y_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT,
    ADVANCE,
    DONE
  } state_t;

  state_t           state;
  logic [15:0]      shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       half_cnt;

  // MOSI is the top of the shift register, so it changes together with the falling SCK.
  assign spi_mosi = shreg[15];
  assign spi_dc   = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      next_pixel <= 1'b0;
      spi_cs     <= 1'b1;
      spi_clk    <= 1'b0;
      shreg      <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            busy       <= 1'b1;
            spi_cs     <= 1'b0;
            x          <= '0;
            y          <= '0;
            next_pixel <= 1'b1;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (color_done) begin
            state      <= SHIFT;
            shreg      <= color;
            next_pixel <= 1'b0;
            spi_clk    <= 1'b0;
            div_cnt    <= '0;
            half_cnt   <= '0;
          end
        end
        SHIFT: begin
          // 32 half-periods of CLK_DIV cycles each; even halves low, odd halves high.
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == 5'd31) begin
              state   <= ADVANCE;
              spi_clk <= 1'b0;
              shreg   <= '0;
            end else begin
              half_cnt <= half_cnt + 5'd1;
              spi_clk  <= ~spi_clk;
              if (half_cnt[0]) shreg <= {shreg[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ADVANCE: begin
          if (x != X_LAST) begin
            x          <= x + 8'd1;
            next_pixel <= 1'b1;
            state      <= REQ;
          end else if (y != Y_LAST) begin
            x          <= '0;
            y          <= y + 7'd1;
            next_pixel <= 1'b1;
            state      <= REQ;
          end else begin
            state      <= DONE;
            frame_done <= 1'b1;
            spi_cs     <= 1'b1;
            busy       <= 1'b0;
            x          <= '0;
            y          <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: a cycle-schedule model of each pixel (request, wait,
// shift, advance) checked every cycle, plus hand-derived timing and serialisation values.
`timescale 1ns/1ps
module tb_oled_pixel_streamer;

  localparam int XM        = 4;
  localparam int YM        = 2;
  localparam int CD        = 2;
  localparam int NPIX      = XM * YM;
  localparam int SHIFT_LEN = 32 * CD;

  logic        clk = 1'b0;
  logic        rst, start, color_done, spur_cd;
  logic [15:0] color;
  logic        busy, frame_done, next_pixel, spi_cs, spi_clk, spi_mosi, spi_dc;
  logic [7:0]  x;
  logic [6:0]  y;

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  always #5 clk = ~clk;

  oled_pixel_streamer #(.X_MAX(XM), .Y_MAX(YM), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .x(x), .y(y), .next_pixel(next_pixel), .color(color), .color_done(color_done),
    .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Responder controls
  int          resp_delay = 3;
  bit          resp_rand  = 1'b0;
  bit          fix_col    = 1'b0;
  logic [15:0] fix_val    = 16'h0000;

  initial begin
    int   cnt;
    logic npp;
    cnt = 0;
    npp = 1'b0;
    color_done = 1'b0;
    color = '0;
    forever begin
      @(posedge clk); #2;
      color_done = 1'b0;
      color = 16'($urandom);
      if (rst) begin
        cnt = 0;
        npp = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            color_done = 1'b1;
            color = fix_col ? fix_val : 16'($urandom);
          end
        end
        if (next_pixel && !npp) cnt = resp_rand ? int'($urandom_range(6, 1)) : resp_delay;
        npp = next_pixel;
      end
      if (spur_cd) color_done = 1'b1;
    end
  end

  // Model: pixel index plus cycle offset t from that pixel's request cycle.
  // m_w = wait length once colour arrives (0 while still waiting).
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_pix  = 0;
  int          m_t    = 0;
  int          m_w    = 0;
  logic [15:0] m_col  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_pix <= 0; m_t <= 0; m_w <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_pix <= 0; m_t <= 0; m_w <= 0;
      end
    end else begin
      if (m_w == 0 && m_t >= 1 && color_done) begin
        m_w   <= m_t;
        m_col <= color;
      end
      if (m_w != 0 && m_t == m_w + SHIFT_LEN + 1) begin
        if (m_pix == NPIX - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_pix <= m_pix + 1; m_t <= 0; m_w <= 0;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Stats gathered by the compare process for the directed checks
  int   cyc, np_rises, clk_rises, fd_cnt, clk_rise_np, hi_bad, hi_run;
  int   np_run, np_run_max, cs_hi_busy, busy_cyc, cs_low, cap_n, first_rise, last_rise;
  logic [15:0] cap;
  int   xs[$], ys[$], periods[$];
  logic np_prev = 1'b0, clk_prev = 1'b0;

  task automatic clr_stats();
    cyc = 0; np_rises = 0; clk_rises = 0; fd_cnt = 0; clk_rise_np = 0; hi_bad = 0;
    hi_run = 0; np_run = 0; np_run_max = 0; cs_hi_busy = 0; busy_cyc = 0; cs_low = 0;
    cap_n = 0; cap = '0; first_rise = -1; last_rise = -1;
    xs.delete(); ys.delete(); periods.delete();
  endtask

  always @(negedge clk) begin
    logic [20:0] act, exp;
    logic        e_busy, e_fd, e_np, e_cs, e_clk, in_shift, e_mosi;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    int          k;
    e_busy = 1'b0; e_fd = 1'b0; e_np = 1'b0; e_cs = 1'b1; e_clk = 1'b0;
    e_x = '0; e_y = '0; in_shift = 1'b0; e_mosi = 1'b0; k = 0;
    if (m_done) begin
      e_fd = 1'b1;
    end else if (m_busy) begin
      e_busy = 1'b1;
      e_cs   = 1'b0;
      e_x    = 8'(m_pix % XM);
      e_y    = 7'(m_pix / XM);
      e_np   = (m_w == 0);
      if (m_w != 0 && m_t >= m_w + 1 && m_t <= m_w + SHIFT_LEN) begin
        in_shift = 1'b1;
        k        = m_t - m_w - 1;
        e_clk    = 1'((k / CD) % 2);
        e_mosi   = m_col[15 - k / (2 * CD)];
      end
    end
    exp = {e_busy, e_fd, e_x, e_y, e_np, e_cs, e_clk, 1'b1};
    act = {busy, frame_done, x, y, next_pixel, spi_cs, spi_clk, spi_dc};
    checks++;
    if (act !== exp) begin
      errors++;
      if (nprint < 20) $display("FAIL model outputs at %0t: got %h expected %h", $time, act, exp);
      nprint++;
    end
    if (in_shift) begin
      checks++;
      if (spi_mosi !== e_mosi) begin
        errors++;
        if (nprint < 20) $display("FAIL model mosi at %0t: got %b expected %b", $time, spi_mosi, e_mosi);
        nprint++;
      end
    end

    cyc++;
    if (next_pixel && !np_prev) begin
      np_rises++;
      xs.push_back(int'(x));
      ys.push_back(int'(y));
      if (last_rise >= 0) periods.push_back(cyc - last_rise);
      else first_rise = cyc;
      last_rise = cyc;
    end
    if (next_pixel) np_run++;
    else begin
      if (np_run > np_run_max) np_run_max = np_run;
      np_run = 0;
    end
    if (spi_clk && !clk_prev) begin
      clk_rises++;
      if (next_pixel) clk_rise_np++;
      if (cap_n < 16) begin
        cap = {cap[14:0], spi_mosi};
        cap_n++;
      end
    end
    if (spi_clk) hi_run++;
    else begin
      if (clk_prev && hi_run != CD) hi_bad++;
      hi_run = 0;
    end
    if (frame_done) fd_cnt++;
    if (busy && spi_cs) cs_hi_busy++;
    if (busy) busy_cyc++;
    if (!spi_cs) cs_low++;
    np_prev  = next_pixel;
    clk_prev = spi_clk;
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < budget) begin
      cyc1();
      n++;
    end
    chk("frame_done_within_budget", int'(fd_cnt > 0), 1);
  endtask

  task automatic chk_periods(input string nm, input int exp);
    int bad;
    bad = 0;
    foreach (periods[i]) if (periods[i] != exp) bad++;
    chk({nm, "_count"}, periods.size(), NPIX - 1);
    chk({nm, "_bad"}, bad, 0);
  endtask

  task automatic chk_raster();
    chk("raster_len", xs.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      if (i < xs.size()) chk("raster_xy", xs[i] * 256 + ys[i], (i % XM) * 256 + i / XM);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; spur_cd = 1'b0;
    clr_stats();
    repeat (3) cyc1();
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_xy", int'({x, y}), 0);
    chk("rst_next_pixel", int'(next_pixel), 0);
    chk("rst_spi", int'({spi_cs, spi_clk, spi_mosi, spi_dc}), 4'b1001);
    rst = 1'b0;
    cyc1();

    // color_done in IDLE must be ignored
    clr_stats();
    spur_cd = 1'b1; cyc1(); spur_cd = 1'b0;
    repeat (5) cyc1();
    chk("idle_cd_busy", busy_cyc, 0);
    chk("idle_cd_np", np_rises, 0);

    // Frame 1: fixed 3-cycle response, random colours
    resp_delay = 3; resp_rand = 1'b0; fix_col = 1'b0;
    clr_stats();
    start = 1'b1; cyc1(); start = 1'b0;
    wait_done(4000);
    chk("f1_np_rises", np_rises, NPIX);
    chk_raster();
    chk("f1_first_req", first_rise, 2);
    chk_periods("f1_period", 3 + 66);
    chk("f1_frame_done_cycles", fd_cnt, 1);
    chk("f1_after_cs_busy", int'({spi_cs, busy}), 2'b10);
    chk("f1_clk_rises", clk_rises, 16 * NPIX);
    chk("f1_high_phase", hi_bad, 0);

    // Frame 2 back-to-back: fixed colour 0xF81F, response in first WAIT cycle
    resp_delay = 1; fix_col = 1'b1; fix_val = 16'hF81F;
    clr_stats();
    start = 1'b1; cyc1(); start = 1'b0;
    wait_done(4000);
    chk("f2_first_req", first_rise, 2);
    chk("f2_np_rises", np_rises, NPIX);
    chk_raster();
    chk("f2_serial_bits", int'(cap), 16'hF81F);
    chk("f2_serial_n", cap_n, 16);
    chk_periods("f2_period", 1 + 66);
    chk("f2_high_phase", hi_bad, 0);
    chk("f2_clk_rises", clk_rises, 16 * NPIX);

    // Frame 3: 50-cycle stalls, spurious start while waiting
    cyc1();
    resp_delay = 50; fix_col = 1'b0;
    clr_stats();
    start = 1'b1; cyc1(); start = 1'b0;
    repeat (10) cyc1();
    start = 1'b1; cyc1(); start = 1'b0;
    wait_done(6000);
    chk("f3_np_rises", np_rises, NPIX);
    chk("f3_np_high_run", np_run_max, 51);
    chk("f3_clk_rise_during_req", clk_rise_np, 0);
    chk("f3_cs_high_while_busy", cs_hi_busy, 0);
    chk_periods("f3_period", 50 + 66);
    chk("f3_frame_done_cycles", fd_cnt, 1);

    // Frame 4: random response delays and colours
    cyc1();
    resp_rand = 1'b1;
    clr_stats();
    start = 1'b1; cyc1(); start = 1'b0;
    wait_done(4000);
    chk("f4_np_rises", np_rises, NPIX);
    chk("f4_frame_done_cycles", fd_cnt, 1);
    chk_raster();

    // Reset in the middle of shifting
    cyc1();
    resp_rand = 1'b0; resp_delay = 2;
    clr_stats();
    start = 1'b1; cyc1(); start = 1'b0;
    n = 0;
    while (clk_rises < 5 && n < 500) begin
      cyc1();
      n++;
    end
    chk("rs_reached_5_rises", int'(clk_rises >= 5), 1);
    rst = 1'b1; #1;
    chk("rs_cs", int'(spi_cs), 1);
    chk("rs_clk", int'(spi_clk), 0);
    chk("rs_next_pixel", int'(next_pixel), 0);
    chk("rs_busy", int'(busy), 0);
    cyc1();
    rst = 1'b0;
    clr_stats();
    repeat (30) cyc1();
    chk("rs_quiet_np", np_rises, 0);
    chk("rs_quiet_clk", clk_rises, 0);
    chk("rs_quiet_busy", busy_cyc, 0);
    chk("rs_quiet_cs", cs_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/oled_pixel_streamer.md
Name: oled_pixel_streamer

Overview:
- Initiator side of the pixel request interface (x, y, next_pixel, color, color_done) used between the OLED path and the display buffer logic.
- On a start pulse, walks one full frame in raster order and requests each pixel colour from a responder.
- Serialises each 16-bit RGB565 colour onto a 4-wire SPI link to an ST7735 panel.
- Panel init and address-window commands are out of scope; the panel is already configured and expects a data stream.

Parameters:
X_MAX, 160, pixels per line
Y_MAX, 80, lines per frame
CLK_DIV, 2, clk cycles per SPI clock half-period (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  1-cycle pulse: begin a frame
busy  output  1  high from frame start until frame_done
frame_done  output  1  1-cycle pulse after the last pixel is shifted out
x  output  8  pixel column being requested
y  output  7  pixel row being requested
next_pixel  output  1  request strobe; responder acts on its rising edge
color  input  16  RGB565 colour from responder, valid in the color_done cycle
color_done  input  1  1-cycle pulse: color is valid
spi_cs  output  1  chip select, active-low
spi_clk  output  1  SPI clock, mode 0, idles low
spi_mosi  output  1  SPI data, MSB first
spi_dc  output  1  data/command select; held at 1 (data)

Behaviour:
- Reset (async, immediate, including mid-frame): busy=0, frame_done=0, x=0, y=0, next_pixel=0, spi_cs=1, spi_clk=0, spi_mosi=0, spi_dc=1, state IDLE. The shift register and latched colour clear to 0.
- States: IDLE, REQ, WAIT, SHIFT, ADVANCE, DONE.
- IDLE:
  - start=1 moves to REQ on the next edge with x=0, y=0, busy=1, spi_cs=0.
  - color_done is ignored in IDLE.
- REQ:
  - Drive next_pixel=1 for one cycle, then go to WAIT.
- WAIT:
  - Hold next_pixel=1 until color_done=1 is sampled. There is no timeout.
  - In the color_done cycle, latch color into the 16-bit shift register and go to SHIFT.
  - next_pixel=0 from the cycle after color_done.
- SHIFT:
  - Bit b (15 down to 0) is on spi_mosi for 2*CLK_DIV cycles.
  - spi_clk=0 for the first CLK_DIV cycles of each bit and 1 for the second CLK_DIV cycles.
  - The panel samples on the rising edge, so mosi is stable CLK_DIV cycles before it.
  - SHIFT lasts exactly 32*CLK_DIV cycles, then spi_clk=0 and the block goes to ADVANCE.
- ADVANCE (1 cycle, next_pixel=0, which guarantees a low gap before the next rising edge):
  - If x<X_MAX-1: x++, go to REQ.
  - Else if y<Y_MAX-1: x=0, y++, go to REQ.
  - Else go to DONE.
- DONE (1 cycle):
  - frame_done=1, spi_cs=1, busy=0, x=0, y=0.
  - Return to IDLE.
- start while busy=1 is ignored (not queued).
- color_done outside WAIT is ignored. color_done in the same cycle as entry to WAIT is accepted.
- spi_cs stays low for the whole frame, including WAIT stalls. spi_clk stays low during WAIT and ADVANCE.
- Per-pixel period = 1 (REQ) + wait cycles + 32*CLK_DIV (SHIFT) + 1 (ADVANCE). The wait count includes the color_done cycle.
- x and y are stable from REQ until ADVANCE.
- Counters use exact widths. No wrap past X_MAX-1 / Y_MAX-1.

Test Plan:
- Full frame, X_MAX=4, Y_MAX=2, CLK_DIV=1, responder returns color_done 3 cycles after the next_pixel rise:
  - Exactly 8 rising edges of next_pixel.
  - (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - One frame_done pulse; busy falls with it; spi_cs high afterwards.
- Serialisation, colour 0xF81F, CLK_DIV=2:
  - 16 spi_clk rising edges; mosi sampled at those edges reads 1111100000011111.
  - Each spi_clk high phase is 2 cycles; spi_dc=1 throughout.
- Stall: color_done withheld for 50 cycles:
  - next_pixel stays 1 for the 50 cycles; no spi_clk edges; spi_cs stays 0.
  - Shifting resumes the cycle after color_done.
- Reset mid-SHIFT (rst asserted after the 5th spi_clk rise):
  - Same cycle: spi_cs=1, spi_clk=0, next_pixel=0, busy=0.
  - After release, no activity until the next start.
- Spurious events:
  - start pulsed during WAIT → frame proceeds unchanged, still 8 pixels.
  - color_done pulsed in IDLE → no state change, busy stays 0.
- Back-to-back frames: start asserted in the cycle after frame_done → second frame begins at (0,0) with identical timing.
